// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame width, common to the receiver and transmitter.
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5
  } state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a configurable reset value.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= {2{RST_VAL}};
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled at i_clk; one-cycle o_rxdv per good byte, o_frameerr on a low stop bit.
// Define UART_RX_MAJORITY_EN to decide data/stop bits by 2-of-3 vote over the last three cycles of each bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uartrx,
  output logic [7:0] o_rxbyte,
  output logic       o_rxdv,
  output logic       o_frameerr,
  output logic       o_rxactive
);
  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'((CLKS_PER_BIT - 1) / 2);

  logic                 w_rxs;
  logic                 w_bit;
  state_t               r_state;
  logic [15:0]          r_clkcnt;
  logic [2:0]           r_bitindex;
  logic [DATA_BITS-1:0] r_shift;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_uartrx),
    .o_q   (w_rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [15:0] LP_M2 = 16'(CLKS_PER_BIT - 3);
  localparam logic [15:0] LP_M1 = 16'(CLKS_PER_BIT - 2);
  logic [1:0] r_maj;

  // The two earlier votes are captured; the third is the live sample at the decision cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_maj    <= 2'b00;
    else if (r_clkcnt == LP_M2) r_maj[0] <= w_rxs;
    else if (r_clkcnt == LP_M1) r_maj[1] <= w_rxs;
  end

  assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rxs) | (r_maj[1] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_clkcnt   <= 16'd0;
      r_bitindex <= 3'd0;
      r_shift    <= '0;
      o_rxbyte   <= 8'h00;
      o_rxdv     <= 1'b0;
      o_frameerr <= 1'b0;
      o_rxactive <= 1'b0;
    end else begin
      o_rxdv     <= 1'b0;
      o_frameerr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clkcnt   <= 16'd0;
          r_bitindex <= 3'd0;
          if (!w_rxs) r_state <= START;
        end
        START: begin
          if (r_clkcnt == LP_HALF) begin
            r_clkcnt <= 16'd0;
            if (!w_rxs) begin
              o_rxactive <= 1'b1;
              r_state    <= DATA;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_clkcnt <= r_clkcnt + 16'd1;
          end
        end
        DATA: begin
          if (r_clkcnt == LP_LAST) begin
            r_clkcnt            <= 16'd0;
            r_shift[r_bitindex] <= w_bit;
            if (r_bitindex == 3'(DATA_BITS - 1)) r_state <= STOP;
            else                                 r_bitindex <= r_bitindex + 3'd1;
          end else begin
            r_clkcnt <= r_clkcnt + 16'd1;
          end
        end
        STOP: begin
          if (r_clkcnt == LP_LAST) begin
            r_clkcnt   <= 16'd0;
            o_rxactive <= 1'b0;
            if (w_bit) begin
              o_rxbyte <= r_shift;
              o_rxdv   <= 1'b1;
              r_state  <= CLEANUP;
            end else begin
              o_frameerr <= 1'b1;
              r_state    <= BREAK;
            end
          end else begin
            r_clkcnt <= r_clkcnt + 16'd1;
          end
        end
        CLEANUP: r_state <= IDLE;
        // A line stuck low after a framing error must not look like a new start bit.
        BREAK:   if (w_rxs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16: frame-level model predicts strobe cycle, byte and active window.
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = (C - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  typedef struct {
    int         act;
    bit         err;
    logic [7:0] b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pin = 1'b1;
  logic [7:0] o_rxbyte;
  logic       o_rxdv, o_frameerr, o_rxactive;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] last_good = 8'h00;
  ev_t        evq[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_uartrx   (pin),
    .o_rxbyte   (o_rxbyte),
    .o_rxdv     (o_rxdv),
    .o_frameerr (o_frameerr),
    .o_rxactive (o_rxactive)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a frame whose start reaches the pin before edge p0 is midpoint-checked at p0+3+H,
  // stays active for 9 bit times and strobes exactly at the stop-bit decision edge.
  always @(negedge clk) begin
    logic exp_dv, exp_fe, exp_act;
    if (o_rxdv) dv_cnt++;
    if (o_frameerr) fe_cnt++;
    if (rst) begin
      evq.delete();
      last_good = 8'h00;
      chk("rst_rxdv", {31'd0, o_rxdv}, 0);
      chk("rst_frameerr", {31'd0, o_frameerr}, 0);
      chk("rst_rxactive", {31'd0, o_rxactive}, 0);
      chk("rst_rxbyte", {24'd0, o_rxbyte}, 0);
    end else begin
      exp_dv = 1'b0; exp_fe = 1'b0; exp_act = 1'b0;
      if (evq.size() > 0) begin
        if (cyc >= evq[0].act && cyc < evq[0].act + 9*C) exp_act = 1'b1;
        if (cyc == evq[0].act + 9*C) begin
          if (evq[0].err) exp_fe = 1'b1;
          else begin exp_dv = 1'b1; last_good = evq[0].b; end
          void'(evq.pop_front());
        end
      end
      chk("rxdv", {31'd0, o_rxdv}, {31'd0, exp_dv});
      chk("frameerr", {31'd0, o_frameerr}, {31'd0, exp_fe});
      chk("rxactive", {31'd0, o_rxactive}, {31'd0, exp_act});
      chk("rxbyte", {24'd0, o_rxbyte}, {24'd0, last_good});
    end
  end

  // Drives one frame cycle by cycle from a negedge; bl = sender cycles per bit.
  // glitch inverts the pin for one cycle so exactly one of the three votes per bit is wrong.
  task automatic send_frame(input logic [7:0] b, input int bl, input logic stopv,
                            input bit glitch, input int cut);
    logic [9:0] fr;
    logic       v;
    ev_t        e;
    fr = {stopv, b, 1'b0};
    e.act = cyc + 1 + 3 + H;
    e.err = !stopv;
    e.b   = b;
    evq.push_back(e);
    for (int j = 0; j < 10*bl; j++) begin
      if (cut > 0 && j == cut) break;
      v = fr[j / bl];
      if (glitch && j > 1 + H && (j - 1 - H) % C == 0) v = ~v;
      pin = v;
      @(negedge clk);
    end
    if (cut > 0) pin = 1'b1;
  endtask

  task automatic idle(input int n);
    pin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int dv0, fe0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(20);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, C, 1'b1, 1'b0, 0);
    idle(40);
    chk("a5_pulses", dv_cnt - dv0, 1);
    chk("a5_noerr", fe_cnt - fe0, 0);
    chk("a5_byte", {24'd0, o_rxbyte}, 32'hA5);

    dv0 = dv_cnt;
    send_frame(8'h00, C, 1'b1, 1'b0, 0);
    send_frame(8'hFF, C, 1'b1, 1'b0, 0);
    idle(40);
    chk("b2b_pulses", dv_cnt - dv0, 2);
    chk("b2b_byte", {24'd0, o_rxbyte}, 32'hFF);

    dv0 = dv_cnt;
    pin = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_pulses", dv_cnt - dv0, 0);
    chk("glitch_idle_active", {31'd0, o_rxactive}, 0);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, C, 1'b0, 1'b0, 0);
    repeat (40*C) @(negedge clk);
    idle(20);
    chk("ferr_count", fe_cnt - fe0, 1);
    chk("ferr_no_dv", dv_cnt - dv0, 0);
    chk("ferr_byte_held", {24'd0, o_rxbyte}, 32'hFF);
    send_frame(8'h81, C, 1'b1, 1'b0, 0);
    idle(40);
    chk("after_break_byte", {24'd0, o_rxbyte}, 32'h81);
    chk("after_break_pulses", dv_cnt - dv0, 1);

    send_frame(8'h55, C, 1'b1, 1'b0, 5*C + H);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    chk("post_rst_byte", {24'd0, o_rxbyte}, 0);
    idle(20);
    dv0 = dv_cnt;
    send_frame(8'h96, C, 1'b1, 1'b0, 0);
    idle(40);
    chk("post_rst_pulses", dv_cnt - dv0, 1);
    chk("post_rst_96", {24'd0, o_rxbyte}, 32'h96);

    send_frame(8'hC3, C - 1, 1'b1, 1'b0, 0);
    idle(40);
    chk("fast_c3", {24'd0, o_rxbyte}, 32'hC3);
    send_frame(8'h00, C, 1'b1, 1'b0, 0);
    idle(40);
    send_frame(8'hC3, C + 1, 1'b1, 1'b0, 0);
    idle(40);
    chk("slow_c3", {24'd0, o_rxbyte}, 32'hC3);
    send_frame(8'h00, C, 1'b1, 1'b0, 0);
    send_frame(8'hC3, C, 1'b1, MAJ, 0);
    idle(40);
    chk("c3_center", {24'd0, o_rxbyte}, 32'hC3);

    dv0 = dv_cnt;
    for (int k = 0; k < 24; k++) begin
      send_frame(8'($urandom), C, 1'b1, MAJ & 1'($urandom), 0);
      idle($urandom_range(0, 20));
    end
    idle(40);
    chk("rand_pulses", dv_cnt - dv0, 24);

    for (int t = 0; t < 2000 && evq.size() > 0; t++) @(negedge clk);
    chk("drain_timeout", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
